// File: rtl/ram_dp_param.sv
// Parametrised true dual-port synchronous RAM with a reset-driven clear sequencer,
// read-during-write select, optional output register and cross-port collision flag.
// Define RAM_DP_PARITY_EN to add per-word even parity and the parity_err_a/b outputs.
`timescale 1ns/1ps

module ram_dp_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_in_a,
    output logic [DATA_W-1:0] data_out_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_in_b,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_b,
    output logic              collision,
`ifdef RAM_DP_PARITY_EN
    output logic              parity_err_a,
    output logic              parity_err_b,
`endif
    output logic              init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_DP_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              acc_a, acc_b;
    logic              wr_a, wr_b, wr_b_eff;
    logic              same_addr, col_now;
    logic [MEM_W-1:0]  wr_word_a, wr_word_b;
    logic [MEM_W-1:0]  rd_word_a, rd_word_b;
    logic [DATA_W-1:0] next_a, next_b;

    logic [DATA_W-1:0] d1_a, d1_b;
    logic              v1_a, v1_b, col1;
`ifdef RAM_DP_PARITY_EN
    logic              pe_now_a, pe_now_b;
    logic              pe1_a, pe1_b;
`endif

    // Clear sequencer: one word per cycle, READY after the last word is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            ptr       <= '0;
            init_busy <= 1'b1;
        end else if (state == ST_INIT) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) begin
                state     <= ST_READY;
                init_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        acc_a     = (state == ST_READY) && en_a;
        acc_b     = (state == ST_READY) && en_b;
        wr_a      = acc_a && we_a;
        wr_b      = acc_b && we_b;
        same_addr = (addr_a == addr_b);
        // Port A wins a same-address double write; B's store is suppressed.
        wr_b_eff  = wr_b && !(wr_a && same_addr);
        col_now   = acc_a && acc_b && same_addr && (we_a || we_b);
    end

`ifdef RAM_DP_PARITY_EN
    assign wr_word_a = {^data_in_a, data_in_a};
    assign wr_word_b = {^data_in_b, data_in_b};
`else
    assign wr_word_a = data_in_a;
    assign wr_word_b = data_in_b;
`endif

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[ptr] <= '0;
        end else begin
            if (wr_a)
                mem[addr_a] <= wr_word_a;
            if (wr_b_eff)
                mem[addr_b] <= wr_word_b;
        end
    end

    assign rd_word_a = mem[addr_a];
    assign rd_word_b = mem[addr_b];

    // Cross-port readers see pre-edge contents because the array updates non-blocking.
    always_comb begin
        next_a = rd_word_a[DATA_W-1:0];
        next_b = rd_word_b[DATA_W-1:0];
        if (RDW_MODE != 0 && we_a)
            next_a = data_in_a;
        if (RDW_MODE != 0 && we_b)
            next_b = data_in_b;
    end

`ifdef RAM_DP_PARITY_EN
    assign pe_now_a = acc_a && !we_a && (^rd_word_a);
    assign pe_now_b = acc_b && !we_b && (^rd_word_b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_a  <= '0;
            d1_b  <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
            col1  <= 1'b0;
`ifdef RAM_DP_PARITY_EN
            pe1_a <= 1'b0;
            pe1_b <= 1'b0;
`endif
        end else begin
            v1_a  <= acc_a;
            v1_b  <= acc_b;
            col1  <= col_now;
`ifdef RAM_DP_PARITY_EN
            pe1_a <= pe_now_a;
            pe1_b <= pe_now_b;
`endif
            if (acc_a)
                d1_a <= next_a;
            if (acc_b)
                d1_b <= next_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] d2_a, d2_b;
            logic              v2_a, v2_b, col2;
`ifdef RAM_DP_PARITY_EN
            logic              pe2_a, pe2_b;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2_a  <= '0;
                    d2_b  <= '0;
                    v2_a  <= 1'b0;
                    v2_b  <= 1'b0;
                    col2  <= 1'b0;
`ifdef RAM_DP_PARITY_EN
                    pe2_a <= 1'b0;
                    pe2_b <= 1'b0;
`endif
                end else begin
                    v2_a  <= v1_a;
                    v2_b  <= v1_b;
                    col2  <= col1;
`ifdef RAM_DP_PARITY_EN
                    pe2_a <= pe1_a;
                    pe2_b <= pe1_b;
`endif
                    if (v1_a)
                        d2_a <= d1_a;
                    if (v1_b)
                        d2_b <= d1_b;
                end
            end
            assign data_out_a   = d2_a;
            assign data_out_b   = d2_b;
            assign valid_a      = v2_a;
            assign valid_b      = v2_b;
            assign collision    = col2;
`ifdef RAM_DP_PARITY_EN
            assign parity_err_a = pe2_a;
            assign parity_err_b = pe2_b;
`endif
        end else begin : g_noreg
            assign data_out_a   = d1_a;
            assign data_out_b   = d1_b;
            assign valid_a      = v1_a;
            assign valid_b      = v1_b;
            assign collision    = col1;
`ifdef RAM_DP_PARITY_EN
            assign parity_err_a = pe1_a;
            assign parity_err_b = pe1_b;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: dut0 is read-first/1-cycle, dut1 is write-first/2-cycle,
// both driven by the same stimulus.
`timescale 1ns/1ps

module tb_ram_dp_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a, we_a, en_b, we_b;
    logic [4:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;
    logic [7:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic       va0, vb0, va1, vb1, col0, col1, busy0, busy1;
`ifdef RAM_DP_PARITY_EN
    logic       pe_a0, pe_b0, pe_a1, pe_b1;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dp_param #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
        .data_out_a(dout_a0), .valid_a(va0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
        .data_out_b(dout_b0), .valid_b(vb0),
        .collision(col0),
`ifdef RAM_DP_PARITY_EN
        .parity_err_a(pe_a0), .parity_err_b(pe_b0),
`endif
        .init_busy(busy0)
    );

    ram_dp_param #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
        .data_out_a(dout_a1), .valid_a(va1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
        .data_out_b(dout_b1), .valid_b(vb1),
        .collision(col1),
`ifdef RAM_DP_PARITY_EN
        .parity_err_a(pe_a1), .parity_err_b(pe_b1),
`endif
        .init_busy(busy1)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        en_a = 1'b0; we_a = 1'b0;
        en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic req_a(input logic we, input logic [4:0] a, input logic [7:0] d);
        en_a = 1'b1; we_a = we; addr_a = a; din_a = d;
    endtask

    task automatic req_b(input logic we, input logic [4:0] a, input logic [7:0] d);
        en_b = 1'b1; we_b = we; addr_b = a; din_b = d;
    endtask

    task automatic test_reset;
        idle();
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({dout_a0, dout_b0, dout_a1, dout_b1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected 00 00 00 00", dout_a0, dout_b0, dout_a1, dout_b1);
        end
        checks++;
        if ({va0, vb0, va1, vb1, col0, col1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {va0, vb0, va1, vb1, col0, col1});
        end
        checks++;
        if ({busy0, busy1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 11", {busy0, busy1});
        end
    endtask

    // Releases reset and counts cycles until init_busy drops; requests issued meanwhile must be ignored.
    task automatic test_init;
        int cycles;
        bit bad;
        cycles = 0;
        bad = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_a(1'b1, 5'd0, 8'hEE);
        req_b(1'b1, 5'd31, 8'hEE);
        while (busy0 === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
            if (va0 | vb0 | va1 | vb1 | col0 | col1)
                bad = 1'b1;
            addr_a = addr_a + 5'd1;
            addr_b = addr_b - 5'd1;
        end
        idle();
        checks++;
        if (cycles !== 32) begin
            errors++;
            $display("FAIL init_cycles: got %0d expected 32", cycles);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL init_ignore: got valid/collision=1 expected none during INIT");
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL init_busy_dut1: got %b expected 0", busy1);
        end
    endtask

    task automatic test_clear_reads;
        for (int i = 0; i < 32; i++) begin
            req_a(1'b0, 5'(i), 8'h00);
            req_b(1'b0, 5'(31 - i), 8'h00);
            tick();
            idle();
            checks++;
            if (va0 !== 1'b1 || dout_a0 !== 8'h00 || vb0 !== 1'b1 || dout_b0 !== 8'h00) begin
                errors++;
                $display("FAIL clear_read0[%0d]: got va=%b a=%h vb=%b b=%h expected 1 00 1 00", i, va0, dout_a0, vb0, dout_b0);
            end
            tick();
            checks++;
            if (va1 !== 1'b1 || dout_a1 !== 8'h00 || vb1 !== 1'b1 || dout_b1 !== 8'h00) begin
                errors++;
                $display("FAIL clear_read1[%0d]: got va=%b a=%h vb=%b b=%h expected 1 00 1 00", i, va1, dout_a1, vb1, dout_b1);
            end
        end
    endtask

    task automatic test_write_read;
        req_a(1'b1, 5'd3, 8'hA5);
        tick();
        idle();
        req_b(1'b0, 5'd3, 8'h00);
        checks++;
        if (va0 !== 1'b1 || dout_a0 !== 8'h00) begin
            errors++;
            $display("FAIL wr_ack0: got v=%b d=%h expected 1 00", va0, dout_a0);
        end
        tick();
        idle();
        checks++;
        if (vb0 !== 1'b1 || dout_b0 !== 8'hA5) begin
            errors++;
            $display("FAIL rd_after_wr0: got v=%b d=%h expected 1 a5", vb0, dout_b0);
        end
        checks++;
        if (va0 !== 1'b0 || dout_a0 !== 8'h00) begin
            errors++;
            $display("FAIL hold0: got v=%b d=%h expected 0 00", va0, dout_a0);
        end
        checks++;
        if (va1 !== 1'b1 || dout_a1 !== 8'hA5) begin
            errors++;
            $display("FAIL wr_ack1: got v=%b d=%h expected 1 a5", va1, dout_a1);
        end
        tick();
        checks++;
        if (vb1 !== 1'b1 || dout_b1 !== 8'hA5 || va1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_after_wr1: got vb=%b d=%h va=%b expected 1 a5 0", vb1, dout_b1, va1);
        end
        checks++;
        if (vb0 !== 1'b0 || dout_b0 !== 8'hA5) begin
            errors++;
            $display("FAIL hold0_b: got v=%b d=%h expected 0 a5", vb0, dout_b0);
        end
    endtask

    task automatic test_rdw;
        req_a(1'b1, 5'd5, 8'h3C);
        tick(); idle(); tick();
        req_a(1'b1, 5'd5, 8'h7E);
        tick();
        idle();
        checks++;
        if (va0 !== 1'b1 || dout_a0 !== 8'h3C) begin
            errors++;
            $display("FAIL rdw_read_first: got v=%b d=%h expected 1 3c", va0, dout_a0);
        end
        tick();
        checks++;
        if (va1 !== 1'b1 || dout_a1 !== 8'h7E) begin
            errors++;
            $display("FAIL rdw_write_first: got v=%b d=%h expected 1 7e", va1, dout_a1);
        end
        req_a(1'b0, 5'd5, 8'h00);
        tick();
        idle();
        checks++;
        if (dout_a0 !== 8'h7E) begin
            errors++;
            $display("FAIL rdw_reread0: got %h expected 7e", dout_a0);
        end
        tick();
        checks++;
        if (dout_a1 !== 8'h7E) begin
            errors++;
            $display("FAIL rdw_reread1: got %h expected 7e", dout_a1);
        end
    endtask

    task automatic test_collision_ww;
        req_a(1'b1, 5'd7, 8'h11);
        req_b(1'b1, 5'd7, 8'h22);
        tick();
        idle();
        checks++;
        if (col0 !== 1'b1 || dout_a0 !== 8'h00 || dout_b0 !== 8'h00) begin
            errors++;
            $display("FAIL ww0: got col=%b a=%h b=%h expected 1 00 00", col0, dout_a0, dout_b0);
        end
        tick();
        checks++;
        if (col0 !== 1'b0) begin
            errors++;
            $display("FAIL ww_pulse0: got col=%b expected 0", col0);
        end
        checks++;
        if (col1 !== 1'b1 || dout_a1 !== 8'h11 || dout_b1 !== 8'h22) begin
            errors++;
            $display("FAIL ww1: got col=%b a=%h b=%h expected 1 11 22", col1, dout_a1, dout_b1);
        end
        tick();
        checks++;
        if (col1 !== 1'b0) begin
            errors++;
            $display("FAIL ww_pulse1: got col=%b expected 0", col1);
        end
        req_a(1'b0, 5'd7, 8'h00);
        req_b(1'b0, 5'd7, 8'h00);
        tick();
        idle();
        checks++;
        if (dout_a0 !== 8'h11 || dout_b0 !== 8'h11 || col0 !== 1'b0) begin
            errors++;
            $display("FAIL ww_reread0: got a=%h b=%h col=%b expected 11 11 0", dout_a0, dout_b0, col0);
        end
        tick();
        checks++;
        if (dout_a1 !== 8'h11 || dout_b1 !== 8'h11 || col1 !== 1'b0) begin
            errors++;
            $display("FAIL ww_reread1: got a=%h b=%h col=%b expected 11 11 0", dout_a1, dout_b1, col1);
        end
    endtask

    task automatic test_collision_wr;
        req_a(1'b1, 5'd9, 8'h55);
        tick(); idle(); tick();
        req_a(1'b1, 5'd9, 8'h66);
        req_b(1'b0, 5'd9, 8'h00);
        tick();
        idle();
        checks++;
        if (col0 !== 1'b1 || dout_b0 !== 8'h55 || dout_a0 !== 8'h55) begin
            errors++;
            $display("FAIL wr_col0: got col=%b b=%h a=%h expected 1 55 55", col0, dout_b0, dout_a0);
        end
        tick();
        checks++;
        if (col1 !== 1'b1 || dout_b1 !== 8'h55 || dout_a1 !== 8'h66) begin
            errors++;
            $display("FAIL wr_col1: got col=%b b=%h a=%h expected 1 55 66", col1, dout_b1, dout_a1);
        end
        req_b(1'b0, 5'd9, 8'h00);
        tick();
        idle();
        checks++;
        if (dout_b0 !== 8'h66) begin
            errors++;
            $display("FAIL wr_col_reread0: got %h expected 66", dout_b0);
        end
        tick();
        checks++;
        if (dout_b1 !== 8'h66) begin
            errors++;
            $display("FAIL wr_col_reread1: got %h expected 66", dout_b1);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] adr [4];
        logic [7:0] exp_d [4];
        adr[0] = 5'd3;   adr[1] = 5'd5;   adr[2] = 5'd7;   adr[3] = 5'd9;
        exp_d[0] = 8'hA5; exp_d[1] = 8'h7E; exp_d[2] = 8'h11; exp_d[3] = 8'h66;
        for (int k = 0; k < 5; k++) begin
            if (k < 4)
                req_a(1'b0, adr[k], 8'h00);
            else
                idle();
            tick();
            checks++;
            if (k < 4) begin
                if (va0 !== 1'b1 || dout_a0 !== exp_d[k]) begin
                    errors++;
                    $display("FAIL b2b0[%0d]: got v=%b d=%h expected 1 %h", k, va0, dout_a0, exp_d[k]);
                end
            end else if (va0 !== 1'b0 || dout_a0 !== 8'h66) begin
                errors++;
                $display("FAIL b2b0_end: got v=%b d=%h expected 0 66", va0, dout_a0);
            end
            if (k >= 1) begin
                checks++;
                if (va1 !== 1'b1 || dout_a1 !== exp_d[k-1]) begin
                    errors++;
                    $display("FAIL b2b1[%0d]: got v=%b d=%h expected 1 %h", k - 1, va1, dout_a1, exp_d[k-1]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid;
        int cycles;
        req_a(1'b1, 5'd3, 8'hFF);
        tick();
        rst_n = 1'b0;
        #1;
        idle();
        checks++;
        if (dout_a0 !== 8'h00 || va0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset0: got d=%h v=%b busy=%b expected 00 0 1", dout_a0, va0, busy0);
        end
        checks++;
        if (dout_a1 !== 8'h00 || va1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset1: got d=%h v=%b busy=%b expected 00 0 1", dout_a1, va1, busy1);
        end
        tick();
        tick();
        rst_n = 1'b1;
        cycles = 0;
        while (busy0 === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles !== 32) begin
            errors++;
            $display("FAIL reinit_cycles: got %0d expected 32", cycles);
        end
        tick();
        req_a(1'b0, 5'd3, 8'h00);
        tick();
        idle();
        checks++;
        if (va0 !== 1'b1 || dout_a0 !== 8'h00) begin
            errors++;
            $display("FAIL reclear0: got v=%b d=%h expected 1 00", va0, dout_a0);
        end
        tick();
        checks++;
        if (va1 !== 1'b1 || dout_a1 !== 8'h00) begin
            errors++;
            $display("FAIL reclear1: got v=%b d=%h expected 1 00", va1, dout_a1);
        end
    endtask

`ifdef RAM_DP_PARITY_EN
    task automatic test_parity;
        req_a(1'b1, 5'd3, 8'h01);
        tick(); idle(); tick();
        dut0.mem[3][8] = ~dut0.mem[3][8];
        req_a(1'b0, 5'd3, 8'h00);
        tick();
        idle();
        checks++;
        if (pe_a0 !== 1'b1 || dout_a0 !== 8'h01) begin
            errors++;
            $display("FAIL parity_err0: got pe=%b d=%h expected 1 01", pe_a0, dout_a0);
        end
        tick();
        checks++;
        if (pe_a1 !== 1'b0 || dout_a1 !== 8'h01 || pe_a0 !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean1: got pe1=%b d=%h pe0=%b expected 0 01 0", pe_a1, dout_a1, pe_a0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_clear_reads();
        test_write_read();
        test_rdw();
        test_collision_ww();
        test_collision_wr();
        test_back_to_back();
        test_reset_mid();
`ifdef RAM_DP_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
Parametrised true dual-port synchronous RAM. It is the next generation of the team's 32x8 dual-port RAM, generalised in width and depth. Over the current part it adds:
- per-port read/write select
- a selectable read-during-write mode
- an optional output pipeline register
- cross-port collision detection
- a reset-driven memory clear sequencer

It sits as a generic storage primitive shared by datapath blocks.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en_a  in  1  port A access request
we_a  in  1  port A write (1) / read (0), qualified by en_a
addr_a  in  ADDR_W  port A address
data_in_a  in  DATA_W  port A write data
data_out_a  out  DATA_W  port A read data
valid_a  out  1  data_out_a carries the result of an accepted access
en_b, we_b, addr_b, data_in_b, data_out_b, valid_b  same as port A, for port B
collision  out  1  one-cycle pulse: same-address cross-port conflict
init_busy  out  1  memory clear in progress; accesses ignored

Behaviour:
- Reset (rst_n=0, async):
  - data_out_a/b=0, valid_a/b=0, collision=0, init_busy=1.
  - FSM forced to INIT, clear pointer=0.
- FSM states INIT and READY:
  - INIT: each clk writes 0 to mem[ptr], ptr++.
  - When ptr==DEPTH-1 is written, go to READY next cycle. init_busy then drops, after exactly DEPTH cycles following reset release.
  - While in INIT, en_a/en_b are ignored: no write, valid stays 0.
  - READY holds until the next reset.
- Reset asserted mid-INIT or mid-operation: the clear restarts from address 0. In-flight reads are dropped and valid is cleared.
- Port access, READY only:
  - en=1, we=1: write data_in to mem[addr] at the clk edge.
  - en=1, we=0: read mem[addr].
  - Every accepted access, read or write, produces a valid pulse and a data_out value after the latency.
- Latency:
  - OUT_REG=0: data_out/valid update on the edge that samples the request (visible next cycle).
  - OUT_REG=1: one further cycle later. The pipeline advances every cycle with no stall.
- Hold: when no access occurs, data_out holds its last value and valid=0.
- Same-port write data_out: RDW_MODE=0 returns the prior mem contents; RDW_MODE=1 returns data_in.
- Cross-port, both enabled, addr_a==addr_b:
  - Both write: port A data is stored (A priority). Each port's data_out follows its own RDW_MODE rule.
  - One writes, the other reads: the reader gets the old data, regardless of RDW_MODE.
  - Both read: normal, no flag.
  - collision pulses high for one cycle for any same-address case with at least one write. It is aligned with valid (i.e. delayed by OUT_REG).
- Addresses are always in range (DEPTH=2**ADDR_W), so there is no wrap or out-of-range case.

Optional Feature:
Macro RAM_DP_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on write (the clear writes parity 0).
  - Reads recompute parity and drive extra outputs parity_err_a/parity_err_b, aligned with valid. These reset to 0.
  - On error, data_out still returns the stored data.
- Not defined: no parity storage, no parity_err ports, memory width exactly DATA_W.

Test Plan:
1. Defaults; release rst_n → init_busy=1 for 32 cycles then 0. Reads of addr 0..31 each return 0x00 with valid=1. Requests issued during INIT produce no valid.
2. Port A writes 0xA5 to addr 3; next cycle port B reads addr 3 → data_out_b=0xA5 one cycle after the request, valid_b=1. With OUT_REG=1 the same result appears two cycles after the request.
3. mem[5]=0x3C; port A writes 0x7E to addr 5 → data_out_a=0x3C (RDW_MODE=0) or 0x7E (RDW_MODE=1). A subsequent read returns 0x7E in both modes.
4. Same cycle: A writes 0x11, B writes 0x22, both to addr 7 → collision=1 for one cycle; a later read of addr 7 returns 0x11.
5. mem[9]=0x55; A writes 0x66 to addr 9 while B reads addr 9 → data_out_b=0x55, collision=1; next read returns 0x66.
6. Write 0xFF to addr 3, assert rst_n=0 mid-access for 2 cycles → outputs 0 immediately; after the DEPTH-cycle re-clear, a read of addr 3 returns 0x00. With RAM_DP_PARITY_EN defined, forcing a stored parity bit flip makes parity_err=1 on the read.
